sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter BASE0, 8'h00, ROM base address of requester 0 (player ship).
REQ-002 Parameter BASE1, 8'h20, ROM base address of requester 1 (enemy ship).
REQ-003 Parameter BASE2, 8'h40, ROM base address of requester 2 (bullet).
REQ-004 Parameter ROWS0 / ROWS1 / ROWS2, 32 / 32 / 7, valid row count per requester.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  3  per-requester row-fetch request, bit i = requester i.
REQ-008 row0, row1, row2  input  5 each  requested sprite row, sampled in the grant cycle.
REQ-009 gnt  output  3  one-hot, combinational; high in the cycle request i is accepted.
REQ-010 rom_addr  output  8  address to the objects ROM, which registers it internally (1-cycle read latency).
REQ-011 rom_data  input  32  ROM row data, valid the cycle after rom_addr is presented.
REQ-012 rdata  output  32  registered returned sprite row.
REQ-013 rdata_valid  output  3  registered one-hot tag; bit i high for one cycle when rdata belongs to requester i.
REQ-014 busy  output  1  high while any accepted fetch is still in the pipeline.

Function
REQ-015 The block SHALL grant at most one request per cycle, round-robin, using a 2-bit priority pointer ptr (values 0..2).
REQ-016 Arbitration: search req starting at index ptr, ascending mod 3; the first set bit wins.
REQ-017 After a grant to i, ptr SHALL become (i+1) mod 3 at the next edge; with no grant ptr holds.
REQ-018 In the grant cycle N, rom_addr SHALL equal BASEi + rowi (8-bit sum, wrap-around discarded).
REQ-019 With no grant, rom_addr SHALL be 8'h00.
REQ-020 Row check: if rowi >= ROWSi, the request is still granted and consumes its slot, but returned rdata SHALL be 32'h0.
REQ-021 Stage 1 (edge ending cycle N) SHALL register valid, requester id and the out-of-range flag.
REQ-022 Stage 2 (edge ending cycle N+1) SHALL register rdata <= rom_data (or 0 if out-of-range) and rdata_valid <= onehot(id).
REQ-023 rdata_valid SHALL be high in cycle N+2 only; fixed latency 2 cycles from grant; throughput 1 fetch per cycle.
REQ-024 rdata SHALL hold its last value while rdata_valid is 0.
REQ-025 busy SHALL equal stage-1 valid OR any rdata_valid bit.
REQ-026 A requester holding req high SHALL be granted again after at most 2 other grants (no starvation).
REQ-027 Requesters SHALL treat gnt as acceptance: keeping req high the next cycle means a new fetch.
REQ-028 req bits for requesters with no pending need are don't-care to the block; no queuing beyond the 2-stage pipeline.

Reset
REQ-029 While reset is high: ptr = 0, stage-1 valid = 0, rdata = 32'h0, rdata_valid = 3'b000, busy = 0.
REQ-030 gnt SHALL be 3'b000 and rom_addr 8'h00 while reset is high, regardless of req.
REQ-031 Reset asserted mid-operation SHALL discard in-flight fetches; no rdata_valid pulse for them after reset release.
REQ-032 The first grant after reset SHALL follow priority 0 > 1 > 2.

Verification
REQ-033 req=3'b001, row0=2 in cycle N -> gnt=001, rom_addr=8'h02 in N; rdata=32'h00018000, rdata_valid=001 in N+2.
REQ-034 req=3'b010, row1=0 -> rom_addr=8'h20; rdata=32'h000E7000, rdata_valid=010 two cycles later.
REQ-035 req=3'b111 held 4 cycles after reset (rows 0,0,1) -> gnt sequence 001,010,100,001; rdata_valid follows 2 cycles behind with 32'h0, 32'h000E7000, 32'h0003C000, 32'h0.
REQ-036 req=3'b100, row2=9 -> gnt=100; rdata=32'h0, rdata_valid=100 in N+2 (out-of-range).
REQ-037 Grant in cycle N, reset pulsed in N+1 -> no rdata_valid in N+2; busy=0; next req=3'b110 grants requester 1 first.
REQ-038 Back-to-back req=3'b001, row0=0x0F,0x10 -> rdata 32'h03BFFDC0 then 32'h0FFBDFF0 on consecutive cycles, busy high throughout.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Three requesters (player ship, enemy ship, bullet) share one objects ROM.
//   At most one row fetch is accepted per cycle, and the winner is picked
//   round-robin. The accepted fetch returns its row exactly two cycles after
//   the grant. A row index outside the sprite's valid range still uses its
//   slot, but it returns an all-zero row.
//
// Ports
//   clk           single clock, rising edge
//   reset         asynchronous, active-high
//   req[2:0]      per-requester fetch request
//   row0..row2    requested sprite row, sampled in the grant cycle
//   gnt[2:0]      one-hot accept, combinational
//   rom_addr[7:0] ROM address (ROM registers it; data returns next cycle)
//   rom_data[31:0] ROM read data
//   rdata[31:0]   returned sprite row, held between returns
//   rdata_valid   one-hot owner tag of rdata, one-cycle pulse
//   busy          a fetch is still in flight

// Per-requester address generation and row range check.
module sprite_rom_lane #(
  parameter logic [7:0] BASE = 8'h00,
  parameter int         ROWS = 32
) (
  input  logic [4:0] i_row,
  output logic [7:0] o_addr,
  output logic       o_oob
);
  // A 5-bit row can never reach a limit of 32 or more.
  localparam bit         ALL_OK = (ROWS >= 32);
  localparam logic [4:0] LIM    = ALL_OK ? 5'd0 : 5'(ROWS);

  // The 8-bit sum wraps, and the carry is dropped on purpose.
  assign o_addr = BASE + {3'b000, i_row};
  assign o_oob  = !ALL_OK && (i_row >= LIM);
endmodule

module sprite_rom_arbiter #(
  parameter logic [7:0] BASE0 = 8'h00,
  parameter logic [7:0] BASE1 = 8'h20,
  parameter logic [7:0] BASE2 = 8'h40,
  parameter int         ROWS0 = 32,
  parameter int         ROWS1 = 32,
  parameter int         ROWS2 = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [4:0]  row0,
  input  logic [4:0]  row1,
  input  logic [4:0]  row2,
  output logic [2:0]  gnt,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] rdata,
  output logic [2:0]  rdata_valid,
  output logic        busy
);
  localparam int NUM_REQ = 3;

  typedef struct packed {
    logic       vld;
    logic [1:0] id;
    logic       oob;
  } s1_t;

  logic [NUM_REQ-1:0][4:0] w_row;
  logic [NUM_REQ-1:0][7:0] w_addr;
  logic [NUM_REQ-1:0]      w_oob;
  logic                    w_hit;
  logic                    w_win;
  logic [1:0]              w_win_id;

  logic [1:0]  r_ptr;
  s1_t         r_s1;
  logic [31:0] r_rdata;
  logic [2:0]  r_rvld;

  assign w_row = {row2, row1, row0};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    localparam logic [7:0] LB = (g == 0) ? BASE0 : (g == 1) ? BASE1 : BASE2;
    localparam int         LR = (g == 0) ? ROWS0 : (g == 1) ? ROWS1 : ROWS2;
    sprite_rom_lane #(.BASE(LB), .ROWS(LR)) u_lane (
      .i_row  (w_row[g]),
      .o_addr (w_addr[g]),
      .o_oob  (w_oob[g])
    );
  end

  // Round-robin search. Scan upward from r_ptr, wrap modulo 3, and take
  // the first request that is set.
  always_comb begin
    int j;
    w_hit    = 1'b0;
    w_win_id = 2'd0;
    j        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_hit && req[j]) begin
        w_hit    = 1'b1;
        w_win_id = 2'(j);
      end
    end
  end

  // Reset blocks any grant. The pipeline would discard it anyway.
  assign w_win    = w_hit && !reset;
  assign gnt      = w_win ? (3'b001 << w_win_id) : 3'b000;
  assign rom_addr = w_win ? w_addr[w_win_id] : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= 2'd0;
      r_s1    <= '0;
      r_rdata <= 32'h0;
      r_rvld  <= 3'b000;
    end else begin
      if (w_win) r_ptr <= (w_win_id == 2'd2) ? 2'd0 : w_win_id + 2'd1;
      // Stage 1 keeps the fetch metadata while the ROM reads.
      r_s1.vld <= w_win;
      r_s1.id  <= w_win_id;
      r_s1.oob <= w_oob[w_win_id];
      // Stage 2 captures the ROM output and tags it with the owner.
      r_rvld   <= r_s1.vld ? (3'b001 << r_s1.id) : 3'b000;
      if (r_s1.vld) r_rdata <= r_s1.oob ? 32'h0 : rom_data;
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rvld;
  assign busy        = r_s1.vld || (|r_rvld);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [4:0]  row0 = '0, row1 = '0, row2 = '0;
  logic [2:0]  gnt;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic [31:0] rdata;
  logic [2:0]  rdata_valid;
  logic        busy;

  sprite_rom_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .row0(row0), .row1(row1), .row2(row2),
    .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Objects ROM: the address is registered, and data appears the next cycle.
  logic [31:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    int          due;
    logic [2:0]  tag;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int          n_vec = 0, n_err = 0, cyc = 0;
  int          m_ptr = 0;
  logic [31:0] last_data = 32'h0;
  bit          started = 0;
  int          waits[3] = '{0, 0, 0};
  int          base_tab[3] = '{'h00, 'h20, 'h40};
  int          lim_tab[3]  = '{32, 32, 7};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // The monitor retires scoreboard entries when they are due. It also checks
  // idle, hold and busy.
  always @(negedge clk) begin
    if (started && !reset) begin
      logic exp_busy;
      exp_t e;
      exp_busy = 1'b0;
      foreach (q[k]) if (q[k].due == cyc || q[k].due == cyc + 1) exp_busy = 1'b1;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rdata_valid", {29'd0, rdata_valid}, {29'd0, e.tag});
        chk("rdata", rdata, e.data);
        last_data = e.data;
      end else begin
        chk("rdata_valid_idle", {29'd0, rdata_valid}, 32'd0);
        chk("rdata_hold", rdata, last_data);
      end
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    end
  end

  // Apply one cycle of stimulus. Check the combinational grant against the
  // reference model, and queue the return the model predicts.
  task automatic step(input logic [2:0] rq, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c);
    int best, bd, d, rv;
    logic [2:0]  eg;
    logic [7:0]  ea;
    exp_t        e;
    @(posedge clk); #1;
    req = rq; row0 = a; row1 = b; row2 = c;
    @(negedge clk);
    // The winner is the requester with the shortest rotational distance from the pointer.
    best = -1; bd = 9;
    for (int i = 0; i < 3; i++)
      if (rq[i]) begin
        d = (i - m_ptr + 3) % 3;
        if (d < bd) begin bd = d; best = i; end
      end
    if (best < 0) begin
      eg = 3'b000; ea = 8'h00;
    end else begin
      rv = (best == 0) ? int'(a) : (best == 1) ? int'(b) : int'(c);
      eg = 3'(1 << best);
      ea = 8'((base_tab[best] + rv) % 256);
      e.due  = cyc + 2;
      e.tag  = eg;
      e.data = (rv >= lim_tab[best]) ? 32'h0 : rom[ea];
      q.push_back(e);
      m_ptr = (best + 1) % 3;
    end
    chk("gnt", {29'd0, gnt}, {29'd0, eg});
    chk("rom_addr", {24'd0, rom_addr}, {24'd0, ea});
    // A requester that holds its request may wait through at most two other grants.
    for (int i = 0; i < 3; i++) begin
      if (!rq[i] || gnt[i]) waits[i] = 0;
      else if (gnt != 3'b000) begin
        waits[i]++;
        chk("starve", {31'd0, waits[i] > 2}, 32'd0);
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1; req = 3'($urandom_range(0, 7));
    @(negedge clk);
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_addr", {24'd0, rom_addr}, 32'd0);
    chk("rst_rvld", {29'd0, rdata_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    q.delete();
    m_ptr = 0; last_data = 32'h0; waits = '{0, 0, 0};
    @(posedge clk); #1;
    reset = 1'b0; req = 3'b000;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[8'h00] = 32'h0;
    rom[8'h02] = 32'h00018000;
    rom[8'h20] = 32'h000E7000;
    rom[8'h41] = 32'h0003C000;
    rom[8'h0F] = 32'h03BFFDC0;
    rom[8'h10] = 32'h0FFBDFF0;

    started = 1;
    pulse_reset();

    step(3'b001, 5'd2, 5'd0, 5'd0);          // player row 2
    step(3'b010, 5'd0, 5'd0, 5'd0);          // enemy row 0
    step(3'b000, 5'd0, 5'd0, 5'd0);
    step(3'b000, 5'd0, 5'd0, 5'd0);

    pulse_reset();
    repeat (4) step(3'b111, 5'd0, 5'd0, 5'd1);
    step(3'b100, 5'd0, 5'd0, 5'd9);          // bullet out of range
    step(3'b000, 5'd0, 5'd0, 5'd0);
    step(3'b000, 5'd0, 5'd0, 5'd0);

    step(3'b001, 5'd3, 5'd0, 5'd0);          // grant, then reset
    pulse_reset();
    step(3'b110, 5'd0, 5'd4, 5'd2);          // enemy first after reset
    step(3'b000, 5'd0, 5'd0, 5'd0);
    step(3'b000, 5'd0, 5'd0, 5'd0);

    step(3'b001, 5'h0F, 5'd0, 5'd0);         // back to back
    step(3'b001, 5'h10, 5'd0, 5'd0);
    step(3'b000, 5'd0, 5'd0, 5'd0);
    step(3'b000, 5'd0, 5'd0, 5'd0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      else step(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 9)));
    end
    repeat (4) step(3'b000, 5'd0, 5'd0, 5'd0);
    chk("drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
